// File: rtl/sweep_counter_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared encodings for the sweep_counter block and its sub-modules.
//   MODE_*  : run-time sweep mode encodings (value of the 2-bit mode input)
//   state_t : sequencer states ST_IDLE / ST_UP / ST_DOWN
// -----------------------------------------------------------------------------
package sweep_pkg;

    localparam logic [1:0] MODE_UP       = 2'd0;  // one-shot up
    localparam logic [1:0] MODE_UPDN     = 2'd1;  // up, then down, then stop
    localparam logic [1:0] MODE_PINGPONG = 2'd2;  // bounce until stopped
    localparam logic [1:0] MODE_DN       = 2'd3;  // one-shot down

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

endpackage : sweep_pkg

// File: rtl/sweep_counter_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running modulo-TICK_DIVIDE counter that produces the step strobe for
// the sweep sequencer.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset (count -> 0)
//   clear : synchronous clear, restarts the count at 0 on the next edge
//   tick  : high during the last cycle of each TICK_DIVIDE-cycle period
// With TICK_DIVIDE = 1 the count never leaves 0 and tick is constantly high.
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int TICK_DIVIDE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CW   = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIVIDE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule : tick_prescaler

// File: rtl/sweep_counter.sv
// -----------------------------------------------------------------------------
// sweep_counter
// Up/down sweep sequencer. Steps `value` between LOW_VALUE and HIGH_VALUE at
// a rate of one step per TICK_DIVIDE clocks, in one of four modes selected on
// start (one-shot up, up-then-down, ping-pong, one-shot down).
//
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset
//   start      : level request, only acted on while idle (and stop low)
//   stop       : abort back to idle, no done pulse; beats tick and start
//   mode[1:0]  : sweep mode, latched when a start is accepted
//   enabled    : high while sweeping
//   direction  : 1 = counting up, 0 = counting down
//   done       : one-cycle pulse when a one-shot sweep completes
//   value      : current count, 0 whenever not enabled
//   pass_count : (SWEEP_PASS_COUNT_EN only) number of bound turnarounds
//                since the last accepted start, wraps at 255
//
// Optional feature macro: SWEEP_PASS_COUNT_EN adds the pass_count output.
// -----------------------------------------------------------------------------
module sweep_counter
    import sweep_pkg::*;
#(
    parameter int                      COUNTER_SIZE = 4,
    parameter logic [COUNTER_SIZE-1:0] LOW_VALUE    = 4'd1,
    parameter logic [COUNTER_SIZE-1:0] HIGH_VALUE   = 4'd15,
    parameter logic [COUNTER_SIZE-1:0] STEP_VALUE   = 4'd1,
    parameter int                      TICK_DIVIDE  = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    output logic                    enabled,
    output logic                    direction,
    output logic                    done,
    output logic [COUNTER_SIZE-1:0] value
`ifdef SWEEP_PASS_COUNT_EN
    ,
    output logic [7:0]              pass_count
`endif
);

    localparam int CS = COUNTER_SIZE;

    // Turnaround targets are constants: the bound is never repeated, the
    // first value after a turnaround is one step back inside the range.
    localparam logic [CS:0]   HI_LESS_STEP  = {1'b0, HIGH_VALUE} - {1'b0, STEP_VALUE};
    localparam logic [CS:0]   LO_PLUS_STEP  = {1'b0, LOW_VALUE} + {1'b0, STEP_VALUE};
    localparam logic [CS-1:0] TURN_DN_VALUE =
        (HI_LESS_STEP[CS] || (HI_LESS_STEP[CS-1:0] < LOW_VALUE)) ? LOW_VALUE
                                                                 : HI_LESS_STEP[CS-1:0];
    localparam logic [CS-1:0] TURN_UP_VALUE =
        (LO_PLUS_STEP > {1'b0, HIGH_VALUE}) ? HIGH_VALUE : LO_PLUS_STEP[CS-1:0];

    state_t        state_q,   state_d;
    logic [1:0]    mode_q,    mode_d;
    logic [CS-1:0] value_q,   value_d;
    logic          dir_q,     dir_d;
    logic          enabled_q, enabled_d;
    logic          done_q,    done_d;
`ifdef SWEEP_PASS_COUNT_EN
    logic [7:0]    pass_q,    pass_d;
`endif

    logic          tick;
    logic          presc_clear;
    logic [CS:0]   up_sum;
    logic [CS:0]   dn_diff;
    logic [CS-1:0] up_sat;
    logic [CS-1:0] dn_sat;
    logic          start_ok;

    // The prescaler is held at 0 while idle, so the first value of a sweep
    // gets a full TICK_DIVIDE period; stop restarts it at 0 as well.
    assign presc_clear = (state_q == ST_IDLE) || stop;

    tick_prescaler #(
        .TICK_DIVIDE (TICK_DIVIDE)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (presc_clear),
        .tick  (tick)
    );

    // Saturating step in one extra bit so the sum never wraps and the
    // difference never underflows before being clamped to the bounds.
    assign up_sum  = {1'b0, value_q} + {1'b0, STEP_VALUE};
    assign dn_diff = {1'b0, value_q} - {1'b0, STEP_VALUE};
    assign up_sat  = (up_sum > {1'b0, HIGH_VALUE}) ? HIGH_VALUE : up_sum[CS-1:0];
    assign dn_sat  = (dn_diff[CS] || (dn_diff[CS-1:0] < LOW_VALUE)) ? LOW_VALUE
                                                                    : dn_diff[CS-1:0];

    assign start_ok = start && !stop;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        value_d   = value_q;
        dir_d     = dir_q;
        enabled_d = enabled_q;
        done_d    = 1'b0;
`ifdef SWEEP_PASS_COUNT_EN
        pass_d    = pass_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    mode_d    = mode;
                    enabled_d = 1'b1;
`ifdef SWEEP_PASS_COUNT_EN
                    pass_d    = 8'd0;
`endif
                    if (mode == MODE_DN) begin
                        state_d = ST_DOWN;
                        value_d = HIGH_VALUE;
                        dir_d   = 1'b0;
                    end else begin
                        state_d = ST_UP;
                        value_d = LOW_VALUE;
                        dir_d   = 1'b1;
                    end
                end
            end

            ST_UP: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    value_d   = '0;
                    dir_d     = 1'b1;
                    enabled_d = 1'b0;
                end else if (tick) begin
                    if (value_q != HIGH_VALUE) begin
                        value_d = up_sat;
                    end else if ((mode_q == MODE_UPDN) || (mode_q == MODE_PINGPONG)) begin
                        state_d = ST_DOWN;
                        value_d = TURN_DN_VALUE;
                        dir_d   = 1'b0;
`ifdef SWEEP_PASS_COUNT_EN
                        pass_d  = pass_q + 8'd1;
`endif
                    end else begin
                        state_d   = ST_IDLE;
                        value_d   = '0;
                        dir_d     = 1'b1;
                        enabled_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end

            ST_DOWN: begin
                if (stop) begin
                    state_d   = ST_IDLE;
                    value_d   = '0;
                    dir_d     = 1'b1;
                    enabled_d = 1'b0;
                end else if (tick) begin
                    if (value_q != LOW_VALUE) begin
                        value_d = dn_sat;
                    end else if (mode_q == MODE_PINGPONG) begin
                        state_d = ST_UP;
                        value_d = TURN_UP_VALUE;
                        dir_d   = 1'b1;
`ifdef SWEEP_PASS_COUNT_EN
                        pass_d  = pass_q + 8'd1;
`endif
                    end else begin
                        state_d   = ST_IDLE;
                        value_d   = '0;
                        dir_d     = 1'b1;
                        enabled_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = ST_IDLE;
                value_d   = '0;
                dir_d     = 1'b1;
                enabled_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_UP;
            value_q   <= '0;
            dir_q     <= 1'b1;
            enabled_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef SWEEP_PASS_COUNT_EN
            pass_q    <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            value_q   <= value_d;
            dir_q     <= dir_d;
            enabled_q <= enabled_d;
            done_q    <= done_d;
`ifdef SWEEP_PASS_COUNT_EN
            pass_q    <= pass_d;
`endif
        end
    end

    assign enabled   = enabled_q;
    assign direction = dir_q;
    assign done      = done_q;
    assign value     = value_q;
`ifdef SWEEP_PASS_COUNT_EN
    assign pass_count = pass_q;
`endif

endmodule : sweep_counter

// File: tb/tb_sweep_counter.sv
// -----------------------------------------------------------------------------
// tb_sweep_counter
// Directed bench for sweep_counter. Three instances share clock and reset:
//   dut_a : default parameters (step 1, one step per clock)
//   dut_b : STEP_VALUE = 4
//   dut_c : TICK_DIVIDE = 3
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_sweep_counter;

    logic       clk = 1'b0;
    logic       rst;

    logic       start_a, stop_a, en_a, dir_a, done_a;
    logic [1:0] mode_a;
    logic [3:0] val_a;
    logic       start_b, stop_b, en_b, dir_b, done_b;
    logic [1:0] mode_b;
    logic [3:0] val_b;
    logic       start_c, stop_c, en_c, dir_c, done_c;
    logic [1:0] mode_c;
    logic [3:0] val_c;
`ifdef SWEEP_PASS_COUNT_EN
    logic [7:0] pc_a, pc_b, pc_c;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sweep_counter dut_a (
        .clock (clk), .reset (rst), .start (start_a), .stop (stop_a), .mode (mode_a),
        .enabled (en_a), .direction (dir_a), .done (done_a), .value (val_a)
`ifdef SWEEP_PASS_COUNT_EN
        , .pass_count (pc_a)
`endif
    );

    sweep_counter #(.STEP_VALUE (4'd4)) dut_b (
        .clock (clk), .reset (rst), .start (start_b), .stop (stop_b), .mode (mode_b),
        .enabled (en_b), .direction (dir_b), .done (done_b), .value (val_b)
`ifdef SWEEP_PASS_COUNT_EN
        , .pass_count (pc_b)
`endif
    );

    sweep_counter #(.TICK_DIVIDE (3)) dut_c (
        .clock (clk), .reset (rst), .start (start_c), .stop (stop_c), .mode (mode_c),
        .enabled (en_c), .direction (dir_c), .done (done_c), .value (val_c)
`ifdef SWEEP_PASS_COUNT_EN
        , .pass_count (pc_c)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Ping-pong reference for bounds 1..15, step 1: 1..15 then 14..2, period 28.
    function automatic int pp_value(input int idx);
        int p;
        p = idx % 28;
        return (p < 15) ? (p + 1) : (29 - p);
    endfunction

    initial begin
        int seq_b [9];
        int dir_b_exp [9];
        seq_b     = '{1, 5, 9, 13, 15, 11, 7, 3, 1};
        dir_b_exp = '{1, 1, 1, 1, 1, 0, 0, 0, 0};

        rst = 1'b1;
        start_a = 0; stop_a = 0; mode_a = 2'd0;
        start_b = 0; stop_b = 0; mode_b = 2'd0;
        start_c = 0; stop_c = 0; mode_c = 2'd0;
        step();
        step();

        // ---- reset state ----
        chk("rst_value",   32'(val_a),  0);
        chk("rst_enabled", 32'(en_a),   0);
        chk("rst_dir",     32'(dir_a),  1);
        chk("rst_done",    32'(done_a), 0);
`ifdef SWEEP_PASS_COUNT_EN
        chk("rst_pass",    32'(pc_a),   0);
`endif
        rst = 1'b0;
        step();
        $display("tb: reset state checked");

        // ---- mode 0, one-shot up ----
        mode_a = 2'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            chk("m0_value", 32'(val_a), 32'(i));
            chk("m0_done",  32'(done_a), 0);
            chk("m0_en",    32'(en_a),   1);
            step();
        end
        chk("m0_done_pulse", 32'(done_a), 1);
        chk("m0_value_end",  32'(val_a),  0);
        chk("m0_en_end",     32'(en_a),   0);
        step();
        chk("m0_done_clear", 32'(done_a), 0);
        chk("m0_idle_value", 32'(val_a),  0);
        $display("tb: mode 0 sweep 1..15 done");

        // ---- mode 1, step 4 ----
        mode_b = 2'd1; start_b = 1'b1;
        step();
        start_b = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk("m1_value", 32'(val_b), 32'(seq_b[i]));
            chk("m1_dir",   32'(dir_b), 32'(dir_b_exp[i]));
            chk("m1_done",  32'(done_b), 0);
            step();
        end
        chk("m1_done_pulse", 32'(done_b), 1);
        chk("m1_value_end",  32'(val_b),  0);
        $display("tb: mode 1 step-4 sweep done");

        // ---- mode 2, tick divide 3, then stop ----
        mode_c = 2'd2; start_c = 1'b1;
        step();
        start_c = 1'b0;
        for (int c = 0; c < 174; c++) begin
            chk("m2_value", 32'(val_c), 32'(pp_value(c / 3)));
            chk("m2_done",  32'(done_c), 0);
            step();
        end
        chk("m2_value_pre_stop", 32'(val_c), 3);
`ifdef SWEEP_PASS_COUNT_EN
        chk("m2_pass_pre_stop", 32'(pc_c), 4);
`endif
        stop_c = 1'b1;
        step();
        stop_c = 1'b0;
        chk("m2_stop_en",    32'(en_c),   0);
        chk("m2_stop_value", 32'(val_c),  0);
        chk("m2_stop_done",  32'(done_c), 0);
        step();
        chk("m2_idle_done",  32'(done_c), 0);
`ifdef SWEEP_PASS_COUNT_EN
        chk("m2_pass_hold",  32'(pc_c), 4);
`endif
        $display("tb: mode 2 ping-pong with stop done");

        // ---- mode 3, start held high ----
        mode_a = 2'd3; start_a = 1'b1;
        step();
        for (int i = 15; i >= 1; i--) begin
            chk("m3_value", 32'(val_a), 32'(i));
            chk("m3_dir",   32'(dir_a), 0);
            chk("m3_done",  32'(done_a), 0);
            step();
        end
        chk("m3_done_pulse", 32'(done_a), 1);
        chk("m3_value_end",  32'(val_a),  0);
        step();
        chk("m3_restart_value", 32'(val_a),  15);
        chk("m3_restart_en",    32'(en_a),   1);
        chk("m3_restart_done",  32'(done_a), 0);
        start_a = 1'b0;
        stop_a  = 1'b1;
        step();
        stop_a  = 1'b0;
        chk("m3_stop_value", 32'(val_a), 0);
        $display("tb: mode 3 sweep and back-to-back restart done");

        // ---- asynchronous reset mid-sweep ----
        mode_a = 2'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        repeat (6) step();
        chk("ar_value_before", 32'(val_a), 7);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_value", 32'(val_a),  0);
        chk("ar_en",    32'(en_a),   0);
        chk("ar_done",  32'(done_a), 0);
        #1;
        rst = 1'b0;
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            chk("ar_resume_value", 32'(val_a), 32'(i));
            step();
        end
        stop_a = 1'b1;
        step();
        stop_a = 1'b0;
        $display("tb: asynchronous reset mid-sweep done");

        // ---- start with stop in idle ----
        start_a = 1'b1; stop_a = 1'b1;
        step();
        chk("ss_en",    32'(en_a),  0);
        chk("ss_value", 32'(val_a), 0);
        step();
        chk("ss_en2",   32'(en_a),  0);
        start_a = 1'b0; stop_a = 1'b0;
        step();
        $display("tb: start with stop ignored");

        // ---- mode change mid-sweep is ignored ----
        mode_a = 2'd0; start_a = 1'b1;
        step();
        start_a = 1'b0;
        mode_a  = 2'd2;
        for (int i = 1; i <= 15; i++) begin
            chk("mc_value", 32'(val_a), 32'(i));
            step();
        end
        chk("mc_done_pulse", 32'(done_a), 1);
        chk("mc_value_end",  32'(val_a),  0);
        step();
        chk("mc_idle_en",    32'(en_a),   0);
        $display("tb: mid-sweep mode change ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sweep_counter

// File: doc/sweep_counter.md
Name: sweep_counter

Overview:
- Parametrised up/down sweep sequencer; one instance replaces a chained up-counter/down-counter pair plus their start and transition glue.
- Steps `value` between LOW_VALUE and HIGH_VALUE in one of four run-time modes: one-shot up, up-then-down, continuous ping-pong, one-shot down.
- Built-in tick prescaler sets the step rate.
- Drives LED banks directly; `value` is forced to 0 whenever the block is idle.

Parameters:
- COUNTER_SIZE, 4: width of `value`.
- LOW_VALUE, 4'd1: lower sweep bound (unsigned).
- HIGH_VALUE, 4'd15: upper sweep bound (unsigned). Must be > LOW_VALUE.
- STEP_VALUE, 4'd1: unsigned step magnitude, ≥ 1. Direction comes from state, not from a two's-complement step.
- TICK_DIVIDE, 1: clock cycles per step, ≥ 1. A value of 1 steps every cycle.

Ports:
- clock, input, 1: sole clock; rising edge.
- reset, input, 1: asynchronous, active-high.
- start, input, 1: level; acted on only in IDLE.
- stop, input, 1: abort; returns to IDLE with no done pulse.
- mode, input, 2: 0 up one-shot, 1 up-then-down, 2 ping-pong, 3 down one-shot. Latched on accepted start.
- enabled, output, 1: high while sweeping.
- direction, output, 1: 1 = counting up, 0 = down. Valid while enabled.
- done, output, 1: one-cycle pulse when a one-shot sweep completes.
- value, output, COUNTER_SIZE: current count; 0 when not enabled.

Behaviour:
- Reset (async): state IDLE, value 0, enabled 0, direction 1, done 0, prescaler 0, latched mode 0.
- States: IDLE, UP, DOWN.
- Accepted start:
  - Condition: IDLE & start & ~stop.
  - Next edge: latch mode, clear prescaler, enabled 1.
  - Modes 0/1/2: value = LOW_VALUE, state UP.
  - Mode 3: value = HIGH_VALUE, state DOWN.
- start while UP/DOWN is ignored.
- Tick: prescaler counts 0..TICK_DIVIDE-1; tick = (prescaler == TICK_DIVIDE-1). Each value is held for exactly TICK_DIVIDE cycles.
- UP, on tick:
  - If value ≠ HIGH_VALUE: value = min(value + STEP_VALUE, HIGH_VALUE). Sum is computed in COUNTER_SIZE+1 bits, so it never wraps.
  - If value == HIGH_VALUE:
    - Mode 0: go IDLE; done=1 for one cycle; value 0; enabled 0.
    - Modes 1/2: go DOWN; value = max(HIGH_VALUE − STEP_VALUE, LOW_VALUE).
- DOWN, on tick:
  - If value ≠ LOW_VALUE: value = max(value − STEP_VALUE, LOW_VALUE). Difference is computed in COUNTER_SIZE+1 bits, so it never underflows.
  - If value == LOW_VALUE:
    - Modes 1/3: go IDLE; done pulse; value 0.
    - Mode 2: go UP; value = min(LOW_VALUE + STEP_VALUE, HIGH_VALUE).
- Terminal values therefore appear for exactly one tick period. Turnaround does not repeat the bound value.
- stop in UP/DOWN: next edge goes IDLE; value 0, enabled 0, done 0, prescaler 0. stop has priority over tick and over start.
- Mode 2 runs until stop or reset; it never asserts done.
- done and a new accepted start may occur on back-to-back cycles. The cycle after done is IDLE and may accept start.
- Reset mid-sweep clears immediately; there is no done pulse.
- mode changes while enabled are ignored until the next start.

Optional Feature:
- Macro: SWEEP_PASS_COUNT_EN.
- Defined:
  - Adds output `pass_count` [7:0], reset 0.
  - Cleared on accepted start.
  - Increments (wrapping at 255→0) on every bound turnaround: UP→DOWN and DOWN→UP, all modes.
  - Holds its value in IDLE.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Shared package `sweep_pkg` holds:
  - Mode encodings MODE_UP=2'd0, MODE_UPDN=2'd1, MODE_PINGPONG=2'd2, MODE_DN=2'd3.
  - State encodings ST_IDLE, ST_UP, ST_DOWN.
- One sub-module, `tick_prescaler`:
  - Parameter: TICK_DIVIDE.
  - Ports: clock, reset, clear, tick.
  - Instantiated once.
- Saturating add/subtract is inline in the parent.

Test Plan:
- Defaults, mode 0, TICK_DIVIDE=1; pulse start one cycle → value 1,2,…,15 on consecutive cycles; done one cycle after 15; value 0, enabled 0 thereafter.
- Mode 1, STEP_VALUE=4, bounds 1..15 → sequence 1,5,9,13,15,11,7,3,1; then done; direction flips at the 15→11 transition.
- Mode 2, TICK_DIVIDE=3, run two full periods, then assert stop → each value held 3 cycles; no done; IDLE one cycle after stop. With SWEEP_PASS_COUNT_EN, pass_count = 4 before stop.
- Mode 3 → 15,14,…,1 then done. start held high throughout → ignored while enabled. Re-accepted on the cycle after done, restarting at 15.
- Reset asserted asynchronously mid-sweep (value 7, between clock edges) → value, enabled, done go 0 immediately without a clock edge; start one cycle after reset release sweeps normally.
- start and stop asserted together in IDLE → no start. mode changed from 0 to 2 mid-sweep → sweep still ends with done at 15.
